// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly; out_valid Nr cycles after accept.
// in_ready only in IDLE; result held in DONE until out_ready. Define AES_ABORT_EN to add the abort input.
module aes_encrypt_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_plaintext,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_ciphertext,
    output logic                busy
`ifdef AES_ABORT_EN
    ,
    input  logic                abort
`endif
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_encrypt_iter: KEY_BITS must be 128 or 256");
    end

    localparam logic [3:0] LAST_ROUND = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    // Entry x sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte 4c+r holds row r of column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_e                state_q, state_d;
    logic [127:0]          blk_q, blk_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [3:0]            round_q, round_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic [127:0]          ct_q, ct_d;

    logic [127:0]          rk;
    logic [KEY_BITS-1:0]   key_adv;
    logic                  rcon_use;

    if (KEY_BITS == 256) begin : g_key256
        logic        even_round;
        logic [31:0] sw_in, t, n0, n1, n2, n3;
        // Window holds the last 8 key words; round 1 uses its lower half as-is.
        always_comb begin
            even_round = ~round_q[0];
            sw_in      = even_round ? {key_q[23:0], key_q[31:24]} : key_q[31:0];
            t          = sub_word(sw_in) ^ (even_round ? {rcon_q, 24'h0} : 32'h0);
            n0         = key_q[KEY_BITS-1 -: 32] ^ t;
            n1         = key_q[KEY_BITS-33 -: 32] ^ n0;
            n2         = key_q[KEY_BITS-65 -: 32] ^ n1;
            n3         = key_q[KEY_BITS-97 -: 32] ^ n2;
            if (round_q == 4'd1) begin
                rk       = key_q[127:0];
                key_adv  = key_q;
                rcon_use = 1'b0;
            end else begin
                rk       = {n0, n1, n2, n3};
                key_adv  = {key_q[127:0], n0, n1, n2, n3};
                rcon_use = even_round;
            end
        end
    end else begin : g_key128
        logic [31:0] t, n0, n1, n2, n3;
        always_comb begin
            t        = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0};
            n0       = key_q[127:96] ^ t;
            n1       = key_q[95:64] ^ n0;
            n2       = key_q[63:32] ^ n1;
            n3       = key_q[31:0] ^ n2;
            rk       = {n0, n1, n2, n3};
            key_adv  = {n0, n1, n2, n3};
            rcon_use = 1'b1;
        end
    end

    logic         last_round;
    logic [127:0] shifted;
    logic [127:0] round_out;

    always_comb begin
        last_round = (round_q == LAST_ROUND);
        shifted    = shift_rows(sub_bytes(blk_q));
        round_out  = (last_round ? shifted : mix_columns(shifted)) ^ rk;
    end

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        key_d       = key_q;
        rcon_d      = rcon_q;
        round_d     = round_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        ct_d        = ct_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    blk_d      = in_plaintext ^ in_key[KEY_BITS-1 -: 128];
                    key_d      = in_key;
                    rcon_d     = 8'h01;
                    round_d    = 4'd1;
                    state_d    = S_ROUND;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_ROUND: begin
                blk_d = round_out;
                key_d = key_adv;
                if (rcon_use) begin
                    rcon_d = xtime(rcon_q);
                end
                if (last_round) begin
                    ct_d        = round_out;
                    out_valid_d = 1'b1;
                    round_d     = 4'd0;
                    state_d     = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                round_d     = 4'd0;
            end
        endcase
`ifdef AES_ABORT_EN
        // Abort drops the block but leaves the previous ciphertext on the bus.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            round_d     = 4'd0;
            ct_d        = ct_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            rcon_q      <= 8'h01;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ct_q        <= '0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ct_q        <= ct_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign out_ciphertext = ct_q;

endmodule
